// File: rtl/floo_tcdm_pkg.sv
// rtl/floo_tcdm_pkg.sv - TCDM request/response types and address helpers

`define FLOO_TCDM_TYPEDEF_REQ_T(req_t, aw, dw, iw) \
    typedef struct packed { \
        logic [(aw)-1:0]     tgt_addr; \
        logic [(iw)-1:0]     src_id; \
        logic                wen; \
        logic [(dw)/8-1:0]   be; \
        logic [(dw)-1:0]     data; \
    } req_t;

`define FLOO_TCDM_TYPEDEF_RSP_T(rsp_t, dw, iw) \
    typedef struct packed { \
        logic [(iw)-1:0]     src_id; \
        logic [(dw)-1:0]     data; \
        logic                err; \
    } rsp_t;

package floo_tcdm_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;

    `FLOO_TCDM_TYPEDEF_REQ_T(tcdm_req_t, AddrWidth, DataWidth, IdWidth)
    `FLOO_TCDM_TYPEDEF_RSP_T(tcdm_rsp_t, DataWidth, IdWidth)

    // Number of byte-offset bits below the SRAM word index.
    function automatic int unsigned byte_off(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/floo_tcdm_mem_fifo.sv
// rtl/floo_tcdm_mem_fifo.sv - registered-output (non fall-through) response FIFO

module floo_tcdm_mem_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0] count_q;
    logic                full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntWidth'(Depth));
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + PtrWidth'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/floo_tcdm_mem_pipe.sv
// rtl/floo_tcdm_mem_pipe.sv - fixed-latency valid/tag shift register tracking SRAM reads

module floo_tcdm_mem_pipe #(
    parameter int unsigned Latency = 1,
    parameter int unsigned Width   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [Width-1:0] tag_i,
    output logic             valid_o,
    output logic [Width-1:0] tag_o
);

    logic [Latency-1:0] valid_q;
    logic [Width-1:0]   tag_q [Latency];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < int'(Latency); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q[0] <= tag_i;
        for (int i = 1; i < int'(Latency); i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign valid_o = valid_q[Latency-1];
    assign tag_o   = tag_q[Latency-1];

endmodule

// File: rtl/floo_tcdm_mem_responder.sv
// rtl/floo_tcdm_mem_responder.sv - TCDM endpoint driving one SRAM bank, credit-buffered responses
// Optional out-of-range error responses: FLOO_TCDM_MEM_RANGE_CHECK_EN.

module floo_tcdm_mem_responder
    import floo_tcdm_pkg::*;
#(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned RspFifoDepth = 4,
    parameter type tcdm_req_t = floo_tcdm_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t = floo_tcdm_pkg::tcdm_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  tcdm_req_t                tcdm_req_i,
    input  logic                     tcdm_req_valid_i,
    output logic                     tcdm_req_ready_o,
    output tcdm_rsp_t                tcdm_rsp_o,
    output logic                     tcdm_rsp_valid_o,
    input  logic                     tcdm_rsp_ready_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [MemAddrWidth-1:0]  mem_addr_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    input  logic [DataWidth-1:0]     mem_rdata_i
);

    localparam int unsigned ByteOff  = byte_off(DataWidth);
    localparam int unsigned TagWidth = IdWidth + 2;
    localparam int unsigned CntWidth = $clog2(RspFifoDepth + 1);
    localparam int unsigned RspWidth = $bits(tcdm_rsp_t);

    if (MemLatency < 1) begin : gen_latency_check
        $error("MemLatency must be at least 1");
    end
    if (RspFifoDepth < MemLatency + 1) begin : gen_depth_check
        $error("RspFifoDepth must be at least MemLatency+1");
    end

    logic                 accept, pop, addr_err, pipe_valid, fifo_empty;
    logic [TagWidth-1:0]  tag_in, tag_out;
    logic [CntWidth-1:0]  credits_q;
    tcdm_rsp_t            rsp_in, rsp_out;
    logic                 unused_addr;

    // Credits are free FIFO slots minus accesses still in the SRAM pipe.
    assign tcdm_req_ready_o = (credits_q != '0);
    assign accept           = tcdm_req_valid_i && tcdm_req_ready_o;
    assign tcdm_rsp_valid_o = !fifo_empty;
    assign pop              = tcdm_rsp_valid_o && tcdm_rsp_ready_i;
    assign tcdm_rsp_o       = rsp_out;
    assign unused_addr      = ^tcdm_req_i.tgt_addr;

`ifdef FLOO_TCDM_MEM_RANGE_CHECK_EN
    assign addr_err = ((tcdm_req_i.tgt_addr >> (ByteOff + MemAddrWidth)) != '0);
`else
    assign addr_err = 1'b0;
`endif

    assign mem_req_o   = accept && !addr_err;
    assign mem_we_o    = tcdm_req_i.wen;
    assign mem_addr_o  = tcdm_req_i.tgt_addr[ByteOff +: MemAddrWidth];
    assign mem_be_o    = tcdm_req_i.be;
    assign mem_wdata_o = tcdm_req_i.data;
    assign tag_in      = {tcdm_req_i.src_id, tcdm_req_i.wen, addr_err};

    floo_tcdm_mem_pipe #(
        .Latency (MemLatency),
        .Width   (TagWidth)
    ) i_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept),
        .tag_i   (tag_in),
        .valid_o (pipe_valid),
        .tag_o   (tag_out)
    );

    always_comb begin
        rsp_in        = '0;
        rsp_in.src_id = tag_out[TagWidth-1:2];
        rsp_in.err    = tag_out[0];
        rsp_in.data   = (tag_out[1] || tag_out[0]) ? '0 : mem_rdata_i;
    end

    floo_tcdm_mem_fifo #(
        .Depth   (RspFifoDepth),
        .Width   (RspWidth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pipe_valid),
        .data_i  (rsp_in),
        .pop_i   (pop),
        .data_o  (rsp_out),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= CntWidth'(RspFifoDepth);
        end else begin
            case ({accept, pop})
                2'b10:   credits_q <= credits_q - CntWidth'(1);
                2'b01:   credits_q <= credits_q + CntWidth'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_floo_tcdm_mem_responder.sv
// tb/tb_floo_tcdm_mem_responder.sv - self-checking bench for floo_tcdm_mem_responder

module tb_floo_tcdm_mem_responder;
    import floo_tcdm_pkg::*;

    localparam int unsigned MemLatency   = 2;
    localparam int unsigned RspFifoDepth = 4;
    localparam int unsigned MemAddrWidth = 10;

    logic        clk = 1'b0;
    logic        rst;
    tcdm_req_t   tcdm_req;
    logic        req_valid, req_ready;
    tcdm_rsp_t   tcdm_rsp;
    logic        rsp_valid, rsp_ready;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    tcdm_rsp_t   exp_q [$];
    tcdm_rsp_t   obs_q [$];
    int          obs_cyc_q [$];
    logic [63:0] ref_mem [int unsigned];

    logic [63:0] sram [1024];
    logic [63:0] rd_pipe [MemLatency];

    always #5 clk = ~clk;

    floo_tcdm_mem_responder #(
        .AddrWidth    (32),
        .DataWidth    (64),
        .IdWidth      (4),
        .MemAddrWidth (MemAddrWidth),
        .MemLatency   (MemLatency),
        .RspFifoDepth (RspFifoDepth),
        .tcdm_req_t   (tcdm_req_t),
        .tcdm_rsp_t   (tcdm_rsp_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .tcdm_req_i       (tcdm_req),
        .tcdm_req_valid_i (req_valid),
        .tcdm_req_ready_o (req_ready),
        .tcdm_rsp_o       (tcdm_rsp),
        .tcdm_rsp_valid_o (rsp_valid),
        .tcdm_rsp_ready_i (rsp_ready),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_be_o         (mem_be),
        .mem_wdata_o      (mem_wdata),
        .mem_rdata_i      (mem_rdata)
    );

    // Fixed-latency SRAM environment.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                rd_pipe[0] <= sram[mem_addr];
            end
        end
        for (int i = 1; i < int'(MemLatency); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MemLatency-1];

    function automatic tcdm_req_t mk(input logic wen, input logic [31:0] addr, input logic [3:0] src,
                                     input logic [63:0] data, input logic [7:0] be);
        tcdm_req_t r;
        r.tgt_addr = addr;
        r.src_id   = src;
        r.wen      = wen;
        r.be       = be;
        r.data     = data;
        return r;
    endfunction

    // Reference: word memory plus an in-order queue of expected responses.
    task automatic model_accept(input tcdm_req_t r);
        tcdm_rsp_t   e;
        int unsigned idx;
        idx      = int'(r.tgt_addr[3 +: 10]);
        e.src_id = r.src_id;
        e.data   = '0;
        e.err    = 1'b0;
`ifdef FLOO_TCDM_MEM_RANGE_CHECK_EN
        if (r.tgt_addr >= 32'h2000) begin
            e.err = 1'b1;
            exp_q.push_back(e);
            return;
        end
`endif
        if (r.wen) begin
            if (!ref_mem.exists(idx)) ref_mem[idx] = '0;
            for (int b = 0; b < 8; b++) begin
                if (r.be[b]) ref_mem[idx][b*8 +: 8] = r.data[b*8 +: 8];
            end
        end else begin
            e.data = ref_mem.exists(idx) ? ref_mem[idx] : 64'h0;
        end
        exp_q.push_back(e);
    endtask

    // One cycle: entered and left at posedge+1.
    task automatic step(input logic v, input tcdm_req_t r, input logic rr, output logic acc);
        req_valid = v;
        tcdm_req  = r;
        rsp_ready = rr;
        #1;
        acc = v && req_ready;
        if (acc) model_accept(r);
        if (rsp_valid && rr) begin
            obs_q.push_back(tcdm_rsp);
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while (obs_q.size() < exp_q.size() && n < 40) begin
            step(1'b0, '0, 1'b1, a);
            n++;
        end
        repeat (4) step(1'b0, '0, 1'b1, a);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tcdm_req  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
    endtask

    task automatic test_write_read();
        logic      a;
        tcdm_rsp_t o, e;
        step(1'b1, mk(1'b1, 32'h40, 4'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF), 1'b1, a);
        step(1'b1, mk(1'b0, 32'h40, 4'd3, 64'h0, 8'hFF), 1'b1, a);
        drain();
        n_checks++;
        if (obs_q.size() != 2) begin
            n_errors++; $display("FAIL wr_rd_count: got %0d want 2", obs_q.size());
        end
        if (obs_q.size() == 2) begin
            o = obs_q[0];
            e = '{src_id: 4'd3, data: 64'h0, err: 1'b0};
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL wr_rsp: got %h want %h", o, e);
            end
            o = obs_q[1];
            e = '{src_id: 4'd3, data: 64'hDEAD_BEEF_0123_4567, err: 1'b0};
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL rd_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_back_to_back();
        logic      a;
        int        first_acc = -1;
        int        not_ready = 0;
        tcdm_rsp_t o, e;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, mk(1'b1, 32'(i * 8), 4'(i), {$urandom, $urandom}, 8'hFF), 1'b1, a);
        end
        drain();
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, mk(1'b0, 32'($urandom_range(0, 15) * 8), 4'($urandom), 64'h0, 8'hFF), 1'b1, a);
            if (!a) not_ready++;
            else if (first_acc < 0) first_acc = cyc - 1;
        end
        n_checks++;
        if (not_ready != 0) begin
            n_errors++; $display("FAIL b2b_ready: stalled %0d cycles want 0", not_ready);
        end
        drain();
        n_checks++;
        if (obs_cyc_q.size() == 0 || obs_cyc_q[0] - first_acc != int'(MemLatency) + 1) begin
            n_errors++;
            $display("FAIL b2b_latency: got %0d want %0d",
                     (obs_cyc_q.size() == 0) ? -1 : obs_cyc_q[0] - first_acc, MemLatency + 1);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL b2b_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_full();
        logic      a;
        int        nacc = 0;
        tcdm_rsp_t held, o, e;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk(1'b0, 32'($urandom_range(0, 15) * 8), 4'($urandom), 64'h0, 8'hFF), 1'b0, a);
            if (a) nacc++;
        end
        n_checks++;
        if (nacc != int'(RspFifoDepth)) begin
            n_errors++; $display("FAIL full_accepts: got %0d want %0d", nacc, RspFifoDepth);
        end
        held = tcdm_rsp;
        step(1'b0, '0, 1'b0, a);
        n_checks++;
        if (rsp_valid !== 1'b1 || tcdm_rsp !== held) begin
            n_errors++; $display("FAIL full_hold: got v=%b %h want v=1 %h", rsp_valid, tcdm_rsp, held);
        end
        step(1'b1, mk(1'b0, 32'h8, 4'd5, 64'h0, 8'hFF), 1'b1, a);
        n_checks++;
        if (a !== 1'b0) begin
            n_errors++; $display("FAIL full_pop_cycle_accept: got %b want 0", a);
        end
        step(1'b1, mk(1'b0, 32'h10, 4'd6, 64'h0, 8'hFF), 1'b0, a);
        n_checks++;
        if (a !== 1'b1) begin
            n_errors++; $display("FAIL full_after_pop_accept: got %b want 1", a);
        end
        step(1'b1, mk(1'b0, 32'h18, 4'd7, 64'h0, 8'hFF), 1'b0, a);
        n_checks++;
        if (a !== 1'b0) begin
            n_errors++; $display("FAIL full_refull_accept: got %b want 0", a);
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL full_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL full_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_accept_pop_same_cycle();
        logic      a;
        tcdm_rsp_t o, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(1'b0, 32'(i * 8 + 8), 4'(i + 1), 64'h0, 8'hFF), 1'b0, a);
        end
        repeat (3) step(1'b0, '0, 1'b0, a);
        step(1'b1, mk(1'b0, 32'h20, 4'd9, 64'h0, 8'hFF), 1'b1, a);
        n_checks++;
        if (a !== 1'b1) begin
            n_errors++; $display("FAIL same_cycle_accept: got %b want 1", a);
        end
        step(1'b1, mk(1'b0, 32'h28, 4'd10, 64'h0, 8'hFF), 1'b0, a);
        n_checks++;
        if (a !== 1'b1) begin
            n_errors++; $display("FAIL same_cycle_credit_kept: got %b want 1", a);
        end
        step(1'b1, mk(1'b0, 32'h30, 4'd11, 64'h0, 8'hFF), 1'b0, a);
        n_checks++;
        if (a !== 1'b0) begin
            n_errors++; $display("FAIL same_cycle_then_full: got %b want 0", a);
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL same_cycle_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL same_cycle_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic      a;
        int        nacc = 0;
        int        bad_valid = 0;
        tcdm_rsp_t o, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(1'b0, 32'(i * 8), 4'(i), 64'h0, 8'hFF), 1'b0, a);
        end
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) bad_valid++;
            step(1'b0, '0, 1'b1, a);
        end
        n_checks++;
        if (bad_valid != 0) begin
            n_errors++; $display("FAIL rst_mid_valid: got %0d valid cycles want 0", bad_valid);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(1'b0, 32'($urandom_range(0, 15) * 8), 4'($urandom), 64'h0, 8'hFF), 1'b0, a);
            if (a) nacc++;
        end
        n_checks++;
        if (nacc != int'(RspFifoDepth)) begin
            n_errors++; $display("FAIL rst_mid_credits: got %0d want %0d", nacc, RspFifoDepth);
        end
        drain();
        step(1'b1, mk(1'b1, 32'h48, 4'd2, 64'h0BAD_F00D_CAFE_1234, 8'h0F), 1'b1, a);
        step(1'b1, mk(1'b0, 32'h48, 4'd2, 64'h0, 8'hFF), 1'b1, a);
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL rst_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL rst_mid_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_range();
        logic      a;
        logic      exp_mem_req;
        tcdm_rsp_t o, e;
        step(1'b1, mk(1'b1, 32'h0, 4'd1, 64'h1122_3344_5566_7788, 8'hFF), 1'b1, a);
        drain();
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
        req_valid = 1'b1;
        tcdm_req  = mk(1'b0, 32'h1_0000, 4'd2, 64'h0, 8'hFF);
        rsp_ready = 1'b1;
        #1;
`ifdef FLOO_TCDM_MEM_RANGE_CHECK_EN
        exp_mem_req = 1'b0;
        e = '{src_id: 4'd2, data: 64'h0, err: 1'b1};
`else
        exp_mem_req = 1'b1;
        e = '{src_id: 4'd2, data: 64'h1122_3344_5566_7788, err: 1'b0};
`endif
        n_checks++;
        if (req_ready !== 1'b1 || mem_req !== exp_mem_req) begin
            n_errors++; $display("FAIL range_mem_req: got %b want %b", mem_req, exp_mem_req);
        end
        n_checks++;
        if (exp_mem_req && mem_addr !== 10'd0) begin
            n_errors++; $display("FAIL range_alias_addr: got %h want 000", mem_addr);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_errors++; $display("FAIL range_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q[0];
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL range_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_random();
        logic      a;
        tcdm_rsp_t o, e;
        for (int i = 0; i < 200; i++) begin
            step(($urandom % 4) != 0,
                 mk(1'($urandom), 32'($urandom_range(0, 15) * 8), 4'($urandom), {$urandom, $urandom},
                    8'($urandom)),
                 ($urandom % 3) != 0, a);
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++; $display("FAIL random_rsp: got %h want %h", o, e);
            end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_full();
        test_accept_pop_same_cycle();
        test_reset_midstream();
        test_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
